// File: rtl/counter_pkg.sv
// counter_pkg: shared enums and next-action helper for the up/down counter channels
package counter_pkg;

    typedef enum logic { DIR_DOWN = 1'b0, DIR_UP = 1'b1 } dir_e;
    typedef enum logic { MODE_WRAP = 1'b0, MODE_SAT = 1'b1 } mode_e;

    // What an enabled step does to the count; kept width-independent so one
    // helper serves every channel width.
    typedef enum logic [2:0] {
        ACT_INC,
        ACT_DEC,
        ACT_ZERO,
        ACT_WRAP_MAX,
        ACT_CLAMP,
        ACT_SAT
    } act_e;

    // An out-of-range count is pulled back to max_val before any direction logic.
    function automatic act_e step_act(input dir_e dir, input mode_e mode, input logic over,
                                      input logic at_max, input logic at_zero);
        return over ? ACT_CLAMP :
               dir == DIR_UP ? (at_max ? (mode == MODE_SAT ? ACT_SAT : ACT_ZERO) : ACT_INC) :
                               (at_zero ? (mode == MODE_SAT ? ACT_SAT : ACT_WRAP_MAX) : ACT_DEC);
    endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel: one WIDTH-bit up/down counter with modulus, wrap/saturate, load and clear
//   clock, reset (async, active-low), clear (sync, clears count and flags)
//   en, up, sat_mode, load, load_val, max_val : per-channel controls
//   carry_in  : gate from the previous channel (tied high when unchained)
//   carry_out : this channel is wrapping on the current step
//   count, wrap_pulse, sat_hit : registered outputs
module counter_channel
    import counter_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    input  logic             up,
    input  logic             sat_mode,
    input  logic             load,
    input  logic             carry_in,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    output logic             carry_out,
    output logic [WIDTH-1:0] count,
    output logic             wrap_pulse,
    output logic             sat_hit
);

    logic             eff;
    act_e             act;
    logic [WIDTH-1:0] nxt;

    always_comb begin
        eff       = en & carry_in;
        act       = step_act(dir_e'(up), mode_e'(sat_mode), count > max_val,
                             count == max_val, count == '0);
        carry_out = eff & ~load & ~sat_mode & (up ? count == max_val : count == '0);
        nxt       = act == ACT_INC ? count + 1'b1 :
                    act == ACT_DEC ? count - 1'b1 :
                    act == ACT_ZERO ? '0 :
                    act == ACT_SAT ? count : max_val;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            sat_hit    <= 1'b0;
        end else if (clear) begin
            count      <= '0;
            wrap_pulse <= 1'b0;
            sat_hit    <= 1'b0;
        end else if (load) begin
            count      <= load_val > max_val ? max_val : load_val;
            wrap_pulse <= 1'b0;
        end else begin
            count      <= eff ? nxt : count;
            wrap_pulse <= eff & (act == ACT_ZERO || act == ACT_WRAP_MAX);
            sat_hit    <= sat_hit | (eff & act == ACT_SAT);
        end
    end

endmodule

// File: rtl/multichannel_updown_counter.sv
// multichannel_updown_counter: bank of CHANNELS chainable up/down counters sharing one modulus
//   clock, reset (async, active-low), clear (sync, all channels)
//   en, up, sat_mode, chain, load : per-channel control bits (chain[0] ignored)
//   load_val : packed load values, channel 0 in the LSBs; max_val : shared terminal value
//   count (packed), wrap_pulse, sat_hit : registered per-channel outputs
module multichannel_updown_counter #(
    parameter int WIDTH    = 12,
    parameter int CHANNELS = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       up,
    input  logic [CHANNELS-1:0]       sat_mode,
    input  logic [CHANNELS-1:0]       chain,
    input  logic [CHANNELS-1:0]       load,
    input  logic [CHANNELS*WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0]          max_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       wrap_pulse,
    output logic [CHANNELS-1:0]       sat_hit
);

    // Per-block carry nets keep the same-cycle ripple free of a vector loop.
    genvar i;
    for (i = 0; i < CHANNELS; i++) begin : ch
        logic cin, cout;
        if (i == 0) begin : head
            assign cin = 1'b1;
        end else begin : link
            assign cin = chain[i] ? ch[i-1].cout : 1'b1;
        end
        counter_channel #(.WIDTH(WIDTH)) u_chan (
            .clock     (clock),
            .reset     (reset),
            .clear     (clear),
            .en        (en[i]),
            .up        (up[i]),
            .sat_mode  (sat_mode[i]),
            .load      (load[i]),
            .carry_in  (cin),
            .load_val  (load_val[i*WIDTH +: WIDTH]),
            .max_val   (max_val),
            .carry_out (cout),
            .count     (count[i*WIDTH +: WIDTH]),
            .wrap_pulse(wrap_pulse[i]),
            .sat_hit   (sat_hit[i])
        );
    end

    // Channel 0 has no predecessor and the last carry has no successor.
    logic unused_ends;
    assign unused_ends = chain[0] ^ ch[CHANNELS-1].cout;

endmodule

// File: tb/tb_multichannel_updown_counter.sv
// tb_multichannel_updown_counter: directed plan plus random stimulus against an arithmetic model
module tb_multichannel_updown_counter;

    localparam int W  = 12;
    localparam int CH = 4;

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            clear = 1'b0;
    logic [CH-1:0]   en = '0, up = '0, sat_mode = '0, chain = '0, load = '0;
    logic [CH*W-1:0] load_val = '0;
    logic [W-1:0]    max_val = '0;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   wrap_pulse, sat_hit;

    int errors = 0;
    int checks = 0;
    int mc[CH], mw[CH], ms[CH];

    multichannel_updown_counter #(.WIDTH(W), .CHANNELS(CH)) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .en        (en),
        .up        (up),
        .sat_mode  (sat_mode),
        .chain     (chain),
        .load      (load),
        .load_val  (load_val),
        .max_val   (max_val),
        .count     (count),
        .wrap_pulse(wrap_pulse),
        .sat_hit   (sat_hit)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Next state from the rules: priority clear > load > step, carries resolved low to high.
    task automatic model_step();
        bit carry_prev = 0;
        for (int i = 0; i < CH; i++) begin
            int  mx    = int'(max_val);
            int  c     = mc[i];
            int  lv    = int'(load_val[i*W +: W]);
            bit  e     = en[i] && (i == 0 || !chain[i] || carry_prev);
            bit  carry = 0;
            if (clear) begin
                mc[i] = 0; mw[i] = 0; ms[i] = 0;
            end else if (load[i]) begin
                mc[i] = lv < mx ? lv : mx; mw[i] = 0;
            end else if (!e) begin
                mw[i] = 0;
            end else if (c > mx) begin
                mc[i] = mx; mw[i] = 0;
            end else if (up[i]) begin
                if (c < mx) begin mc[i] = c + 1; mw[i] = 0; end
                else if (sat_mode[i]) begin ms[i] = 1; mw[i] = 0; end
                else begin mc[i] = 0; mw[i] = 1; carry = 1; end
            end else begin
                if (c > 0) begin mc[i] = c - 1; mw[i] = 0; end
                else if (sat_mode[i]) begin ms[i] = 1; mw[i] = 0; end
                else begin mc[i] = mx; mw[i] = 1; carry = 1; end
            end
            carry_prev = carry;
        end
    endtask

    function automatic logic [63:0] pk(input int sel);
        logic [63:0] r = '0;
        for (int i = 0; i < CH; i++) begin
            if (sel == 0) r[i*W +: W] = W'(mc[i]);
            else if (sel == 1) r[i] = mw[i] != 0;
            else r[i] = ms[i] != 0;
        end
        return r;
    endfunction

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        check("count", count, pk(0));
        check("wrap", wrap_pulse, pk(1));
        check("sat", sat_hit, pk(2));
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            mc[i] = 0; mw[i] = 0; ms[i] = 0;
        end
    endtask

    int wraps;

    initial begin
        model_reset();
        #12;
        check("rst_count", count, 0);
        check("rst_wrap", wrap_pulse, 0);
        check("rst_sat", sat_hit, 0);
        @(negedge clock);
        reset = 1'b1;

        // count up 100, then hold
        max_val = 4095; en[0] = 1; up[0] = 1;
        repeat (100) tick();
        check("p1_up100", count[W-1:0], 100);
        en[0] = 0;
        repeat (100) tick();
        check("p1_hold", count[W-1:0], 100);

        // count down to 0, then wrap to max
        en[0] = 1; up[0] = 0;
        repeat (100) tick();
        check("p2_zero", count[W-1:0], 0);
        tick();
        check("p2_wrap_cnt", count[W-1:0], 4095);
        check("p2_wrap_pulse", wrap_pulse[0], 1);
        en[0] = 0;
        tick();
        check("p2_pulse_drop", wrap_pulse[0], 0);

        // two-digit decade counter
        clear = 1; tick(); clear = 0;
        max_val = 9; chain = 4'b0010; en = 4'b0011; up = '1;
        wraps = 0;
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (wrap_pulse[1]) wraps++;
            if (n == 10) begin
                check("p3_d0_10", count[W-1:0], 0);
                check("p3_d1_10", count[2*W-1:W], 1);
            end
        end
        check("p3_d1_100", count[2*W-1:W], 0);
        check("p3_d1_wraps", wraps, 1);
        check("p3_ch2_idle", count[3*W-1:2*W], 0);

        // saturate at zero
        en = 0; chain = 0; sat_mode = 4'b0100;
        load = 4'b0100; load_val[2*W +: W] = 2;
        tick();
        load = 0; en = 4'b0100; up = 0;
        wraps = 0;
        repeat (5) begin
            tick();
            if (wrap_pulse[2]) wraps++;
        end
        check("p4_cnt", count[3*W-1:2*W], 0);
        check("p4_sat", sat_hit[2], 1);
        check("p4_nowrap", wraps, 0);
        en = 0;
        tick();
        check("p4_sticky", sat_hit[2], 1);
        clear = 1; tick(); clear = 0;
        check("p4_clear", sat_hit[2], 0);

        // load clamp, clear beats load, lowered modulus
        sat_mode = 0; max_val = 9;
        load = 4'b1000; load_val[3*W +: W] = 4000;
        tick();
        check("p5_clamp", count[4*W-1:3*W], 9);
        clear = 1; tick(); clear = 0;
        check("p5_clr_load", count[4*W-1:3*W], 0);
        tick();
        load = 0; max_val = 5; en = 4'b1000; up = 4'b1000;
        tick();
        check("p5_lowered", count[4*W-1:3*W], 5);
        check("p5_nowrap", wrap_pulse[3], 0);

        // random traffic
        repeat (600) begin
            en       = CH'($urandom);
            up       = CH'($urandom);
            sat_mode = CH'($urandom);
            chain    = CH'($urandom);
            load     = $urandom_range(0, 7) == 0 ? CH'($urandom) : '0;
            clear    = $urandom_range(0, 40) == 0;
            load_val = (CH*W)'({$urandom(), $urandom()});
            if ($urandom_range(0, 15) == 0)
                case ($urandom_range(0, 5))
                    0: max_val = 0;
                    1: max_val = 1;
                    2: max_val = 9;
                    3: max_val = 15;
                    4: max_val = 4095;
                    default: max_val = W'($urandom);
                endcase
            tick();
        end

        // asynchronous reset mid-count
        clear = 0; load = 0; chain = 0; sat_mode = 0; en = '1; up = '1; max_val = 4095;
        repeat (20) tick();
        #2 reset = 1'b0;
        #1;
        check("p6_count", count, 0);
        check("p6_wrap", wrap_pulse, 0);
        check("p6_sat", sat_hit, 0);
        model_reset();
        #1 reset = 1'b1;
        tick();
        check("p6_resume", count[W-1:0], 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
